// File: rtl/l2_ecc_reg_cdc_src.sv
// Host-side initiator of the 4-phase register-bus CDC feeding the L2 ECC config registers.
// Latches one reg-bus request, sends it on the req channel and returns the rsp-channel reply.
module l2_ecc_reg_cdc_src #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned SyncStages = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         reg_valid_i,
  input  logic                                         reg_write_i,
  input  logic [AddrWidth-1:0]                         reg_addr_i,
  input  logic [DataWidth-1:0]                         reg_wdata_i,
  input  logic [DataWidth/8-1:0]                       reg_wstrb_i,
  output logic                                         reg_ready_o,
  output logic [DataWidth-1:0]                         reg_rdata_o,
  output logic                                         reg_error_o,
  output logic                                         async_req_o,
  input  logic                                         async_ack_i,
  output logic [AddrWidth+1+DataWidth+DataWidth/8-1:0] async_data_o,
  input  logic                                         async_req_i,
  output logic                                         async_ack_o,
  input  logic [DataWidth:0]                           async_data_i,
  output logic                                         busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ReqWidth  = AddrWidth + 1 + DataWidth + StrbWidth;

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    REQ_LO,
    WAIT_RSP,
    RSP_ACK,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [SyncStages-1:0] ack_sync_q;
  logic [SyncStages-1:0] rreq_sync_q;
  logic [SyncStages-1:0] settle_q;
  logic                  ack_s;
  logic                  rreq_s;
  logic                  quiescent;

  logic                 req_q, req_d;
  logic                 ack_q, ack_d;
  logic [ReqWidth-1:0]  data_q, data_d;
  logic                 ready_q, ready_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;

  assign ack_s  = ack_sync_q[SyncStages-1];
  assign rreq_s = rreq_sync_q[SyncStages-1];

  // Synchronizer contents are meaningless until refilled after reset, so a far
  // side still holding ack/req high must not be mistaken for quiescent.
  assign quiescent = settle_q[SyncStages-1] & ~ack_s & ~rreq_s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ack_sync_q  <= '0;
      rreq_sync_q <= '0;
      settle_q    <= '0;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_sync_q  <= {ack_sync_q[SyncStages-2:0], async_ack_i};
      rreq_sync_q <= {rreq_sync_q[SyncStages-2:0], async_req_i};
      settle_q    <= {settle_q[SyncStages-2:0], 1'b1};
      req_q       <= req_d;
      ack_q       <= ack_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (reg_valid_i && quiescent) state_d = REQ_HI;
      REQ_HI:   if (ack_s)                    state_d = REQ_LO;
      REQ_LO:   if (!ack_s)                   state_d = WAIT_RSP;
      WAIT_RSP: if (rreq_s)                   state_d = RSP_ACK;
      RSP_ACK:  if (!rreq_s)                  state_d = DONE;
      DONE:                                   state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered so nothing reaches a port combinationally.
  always_comb begin
    req_d   = req_q;
    ack_d   = ack_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (state_d == REQ_HI) begin
          req_d  = 1'b1;
          data_d = {reg_addr_i, reg_write_i, reg_wdata_i, reg_wstrb_i};
        end
      end
      REQ_HI:  if (state_d == REQ_LO) req_d = 1'b0;
      WAIT_RSP: begin
        if (state_d == RSP_ACK) begin
          ack_d   = 1'b1;
          rdata_d = async_data_i[DataWidth:1];
          error_d = async_data_i[0];
        end
      end
      RSP_ACK: if (state_d == DONE) ack_d = 1'b0;
      default: ;
    endcase
    ready_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  assign async_req_o  = req_q;
  assign async_ack_o  = ack_q;
  assign async_data_o = data_q;
  assign reg_ready_o  = ready_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_error_o  = error_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_l2_ecc_reg_cdc_src.sv
// Directed bench for l2_ecc_reg_cdc_src: a table of reg-bus transactions against a
// behavioural far-end, plus hand-written sequences for latency, reset and mid-flight changes.
module tb_l2_ecc_reg_cdc_src;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = AW + 1 + DW + DW / 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          reg_valid;
  logic          reg_write;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [3:0]    reg_wstrb;
  logic          reg_ready;
  logic [DW-1:0] reg_rdata;
  logic          reg_error;
  logic          async_req_o;
  logic          async_ack_i;
  logic [RW-1:0] async_data_o;
  logic          async_req_i;
  logic          async_ack_o;
  logic [DW:0]   async_data_i;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;

  // far-end control, written only by the main sequence
  logic          fe_rst;
  logic          fe_force;
  logic          fe_hold;
  int            fe_dly;
  logic [DW-1:0] fe_rdata;
  logic          fe_err;

  always #5 clk = ~clk;

  l2_ecc_reg_cdc_src #(
    .AddrWidth (AW),
    .DataWidth (DW),
    .SyncStages(2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .reg_valid_i (reg_valid),
    .reg_write_i (reg_write),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_wstrb_i (reg_wstrb),
    .reg_ready_o (reg_ready),
    .reg_rdata_o (reg_rdata),
    .reg_error_o (reg_error),
    .async_req_o (async_req_o),
    .async_ack_i (async_ack_i),
    .async_data_o(async_data_o),
    .async_req_i (async_req_i),
    .async_ack_o (async_ack_o),
    .async_data_i(async_data_i),
    .busy_o      (busy)
  );

  typedef struct {
    string         name;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [RW-1:0] exp_data;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[4];

  // Far end: acks the req channel after fe_dly cycles, then issues one response.
  initial begin
    int st;
    int cnt;
    st           = 0;
    cnt          = 0;
    async_ack_i  = 1'b0;
    async_req_i  = 1'b0;
    async_data_i = '0;
    forever begin
      @(negedge clk);
      if (fe_rst) begin
        st           = 0;
        cnt          = 0;
        async_ack_i  = 1'b0;
        async_req_i  = 1'b0;
        async_data_i = '0;
      end else if (fe_force) begin
        async_ack_i = 1'b1;
        st          = 0;
        cnt         = 0;
      end else begin
        case (st)
          0: begin
            async_ack_i = 1'b0;
            if (async_req_o) begin
              if (cnt >= fe_dly) begin
                async_ack_i = 1'b1;
                st          = 1;
                cnt         = 0;
              end else begin
                cnt++;
              end
            end
          end
          1: if (!async_req_o) begin
            async_ack_i = 1'b0;
            st          = 2;
          end
          2: if (!fe_hold) begin
            async_data_i = {fe_rdata, fe_err};
            async_req_i  = 1'b1;
            st           = 3;
          end
          3: if (async_ack_o) begin
            async_req_i = 1'b0;
            st          = 4;
          end
          4: if (!async_ack_o) st = 0;
          default: st = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic drive_req(input vec_t v);
    reg_valid = 1'b1;
    reg_write = v.write;
    reg_addr  = v.addr;
    reg_wdata = v.wdata;
    reg_wstrb = v.wstrb;
    fe_rdata  = v.rsp_rdata;
    fe_err    = v.rsp_err;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " async_req_o"}, 128'(async_req_o), 128'(0));
    check({tag, " async_ack_o"}, 128'(async_ack_o), 128'(0));
    check({tag, " async_data_o"}, 128'(async_data_o), 128'(0));
    check({tag, " reg_ready"}, 128'(reg_ready), 128'(0));
    check({tag, " reg_rdata"}, 128'(reg_rdata), 128'(0));
    check({tag, " reg_error"}, 128'(reg_error), 128'(0));
    check({tag, " busy"}, 128'(busy), 128'(0));
  endtask

  // Full transaction; t_req/t_ack/t_fall are step indices of req rise, ack rise, req fall.
  task automatic run_txn(input vec_t v, output int t_req, output int t_ack, output int t_fall);
    int            pulses;
    bit            seen_req;
    bit            done;
    bit            data_bad;
    bit            busy_bad;
    bit            extra;
    bit            hold_bad;
    logic [DW-1:0] rd;
    logic          er;
    pulses   = 0;
    seen_req = 0;
    done     = 0;
    data_bad = 0;
    busy_bad = 0;
    extra    = 0;
    hold_bad = 0;
    rd       = '0;
    er       = 1'b0;
    t_req    = -1;
    t_ack    = -1;
    t_fall   = -1;
    drive_req(v);
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      if (async_req_o && t_req < 0) t_req = c;
      if (async_ack_i && t_ack < 0) t_ack = c;
      if (t_req >= 0 && !async_req_o && t_fall < 0) t_fall = c;
      if (async_req_o) seen_req = 1;
      if (seen_req && async_data_o !== v.exp_data) data_bad = 1;
      if (seen_req && !busy) busy_bad = 1;
      if (reg_ready) begin
        pulses++;
        rd        = reg_rdata;
        er        = reg_error;
        reg_valid = 1'b0;
        done      = 1;
      end
    end
    check({v.name, " completed"}, 128'(done), 128'(1));
    check({v.name, " async_data stable"}, 128'(data_bad), 128'(0));
    check({v.name, " busy throughout"}, 128'(busy_bad), 128'(0));
    check({v.name, " rdata"}, 128'(rd), 128'(v.exp_rdata));
    check({v.name, " error"}, 128'(er), 128'(v.exp_err));
    for (int c = 0; c < 10; c++) begin
      step();
      if (reg_ready) pulses++;
      if (async_req_o) extra = 1;
      if (reg_rdata !== rd || reg_error !== er) hold_bad = 1;
    end
    check({v.name, " ready pulses"}, 128'(pulses), 128'(1));
    check({v.name, " no reissue"}, 128'(extra), 128'(0));
    check({v.name, " rdata held"}, 128'(hold_bad), 128'(0));
    $display("txn %s addr=%0h write=%0b rdata=%0h err=%0b", v.name, v.addr, v.write, rd, er);
  endtask

  initial begin
    int tr;
    int ta;
    int tf;
    vecs[0] = '{"wr_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0,
                {32'h10, 1'b1, 32'hDEADBEEF, 4'hF}, 32'h0, 1'b0};
    vecs[1] = '{"rd_4", 1'b0, 32'h4, 32'h0, 4'h0, 32'h12345678, 1'b1,
                {32'h4, 1'b0, 32'h0, 4'h0}, 32'h12345678, 1'b1};
    vecs[2] = '{"wr_top", 1'b1, 32'hFFFFFFFC, 32'h0, 4'h5, 32'hA5A5A5A5, 1'b0,
                {32'hFFFFFFFC, 1'b1, 32'h0, 4'h5}, 32'hA5A5A5A5, 1'b0};
    vecs[3] = '{"rd_msb", 1'b0, 32'h80000000, 32'hCAFEF00D, 4'hC, 32'hFFFFFFFF, 1'b0,
                {32'h80000000, 1'b0, 32'hCAFEF00D, 4'hC}, 32'hFFFFFFFF, 1'b0};

    rst_ni    = 1'b0;
    reg_valid = 1'b0;
    reg_write = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_wstrb = '0;
    fe_rst    = 1'b1;
    fe_force  = 1'b0;
    fe_hold   = 1'b0;
    fe_dly    = 3;
    fe_rdata  = '0;
    fe_err    = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst_ni = 1'b1;
    fe_rst = 1'b0;
    repeat (4) step();

    // table of transactions, far end acks after 3 cycles
    foreach (vecs[i]) run_txn(vecs[i], tr, ta, tf);

    // zero-delay far end: latency of req rise and of ack-to-req-fall
    fe_dly = 0;
    run_txn(vecs[1], tr, ta, tf);
    check("zero-dly req rise latency", 128'(tr), 128'(0));
    check("zero-dly ack->req fall", 128'(tf - ta), 128'(3));

    // far end holding ack out of reset with a pending request
    begin
      bit early;
      bit done;
      int t_af;
      early     = 0;
      done      = 0;
      t_af      = -1;
      tr        = -1;
      fe_dly    = 3;
      rst_ni    = 1'b0;
      fe_force  = 1'b1;
      drive_req(vecs[0]);
      repeat (2) step();
      rst_ni = 1'b1;
      for (int c = 0; c < 8; c++) begin
        step();
        if (async_req_o) early = 1;
      end
      check("ack held: no req", 128'(early), 128'(0));
      fe_force = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
        step();
        if (!async_ack_i && t_af < 0) t_af = c;
        if (async_req_o && tr < 0) tr = c;
        if (reg_ready) begin
          reg_valid = 1'b0;
          done      = 1;
        end
      end
      check("ack held: completed", 128'(done), 128'(1));
      check("ack fall->req rise", 128'(tr - t_af), 128'(3));
      repeat (5) step();
    end

    // reset while waiting for the response
    begin
      bit  phase_done;
      bit  seen;
      phase_done = 0;
      seen       = 0;
      fe_dly     = 1;
      fe_hold    = 1'b1;
      drive_req(vecs[3]);
      for (int c = 0; c < 100 && !phase_done; c++) begin
        step();
        if (async_req_o) seen = 1;
        if (seen && !async_req_o && !async_ack_i) phase_done = 1;
      end
      check("wait_rsp reached", 128'(phase_done), 128'(1));
      repeat (4) step();
      check("wait_rsp busy", 128'(busy), 128'(1));
      rst_ni    = 1'b0;
      fe_rst    = 1'b1;
      reg_valid = 1'b0;
      step();
      rst_ni  = 1'b1;
      fe_rst  = 1'b0;
      fe_hold = 1'b0;
      check_all_zero("mid reset");
      repeat (3) step();
      fe_dly = 3;
      run_txn(vecs[2], tr, ta, tf);
    end

    // request inputs change and valid drops while in REQ_LO
    begin
      bit seen;
      bit changed;
      bit done;
      bit data_bad;
      bit extra;
      int pulses;
      seen     = 0;
      changed  = 0;
      done     = 0;
      data_bad = 0;
      extra    = 0;
      pulses   = 0;
      fe_dly   = 2;
      drive_req(vecs[0]);
      for (int c = 0; c < 300 && !done; c++) begin
        step();
        if (async_req_o) seen = 1;
        if (seen && async_data_o !== vecs[0].exp_data) data_bad = 1;
        if (seen && !async_req_o && !changed) begin
          reg_addr  = 32'h0000BAD0;
          reg_wdata = 32'h0BADF00D;
          reg_write = 1'b0;
          reg_valid = 1'b0;
          changed   = 1;
        end
        if (reg_ready) begin
          pulses++;
          done = 1;
        end
      end
      for (int c = 0; c < 15; c++) begin
        step();
        if (reg_ready) pulses++;
        if (async_req_o) extra = 1;
        if (async_data_o !== vecs[0].exp_data) data_bad = 1;
      end
      check("midflight changed in REQ_LO", 128'(changed), 128'(1));
      check("midflight completed", 128'(done), 128'(1));
      check("midflight data stable", 128'(data_bad), 128'(0));
      check("midflight ready pulses", 128'(pulses), 128'(1));
      check("midflight no second txn", 128'(extra), 128'(0));
      $display("txn midflight addr=%0h ready_pulses=%0d", vecs[0].addr, pulses);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
